// File: rtl/rle_pkg.sv
// Shared constants and state type for the run-length encoder/decoder pair.
package rle_pkg;

  localparam int RUN_W    = 10;
  localparam int NUM_RUNS = 3;

  // Largest count a run may hold; the count stops here silently.
  localparam logic [RUN_W-1:0] SAT_MAX    = RUN_W'(1022);
  // Marks a run slot that was never started; the decoder never reaches it.
  localparam logic [RUN_W-1:0] EMPTY_CODE = RUN_W'(1023);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    PUBLISH
  } rle_enc_state_t;

endpackage

// File: rtl/rle_sat_counter.sv
// Loadable up-counter that sticks at SAT_MAX instead of wrapping.
module rle_sat_counter
  import rle_pkg::*;
(
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             load,
  input  logic [RUN_W-1:0] load_val,
  input  logic             inc,
  output logic [RUN_W-1:0] cnt
);

  logic [RUN_W-1:0] r_cnt;

  // Load has priority over increment; increments past SAT_MAX are dropped.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (inc && (r_cnt < SAT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/rle_run_encoder.sv
// Turns a per-pixel binary mask frame into three alternating run lengths
// (0s, 1s, 0s) and publishes them with a one-cycle new_im strobe.
module rle_run_encoder
  import rle_pkg::*;
(
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             pixel_valid,
  input  logic             pixel_bit,
  input  logic             sop,
  input  logic             eop,
  output logic [RUN_W-1:0] stream1,
  output logic [RUN_W-1:0] stream2,
  output logic [RUN_W-1:0] stream3,
  output logic             new_im,
  output logic             overflow,
  output logic             busy
);

  rle_enc_state_t                      r_state;
  logic [1:0]                          r_idx;
  logic                                r_curSym;
  logic [NUM_RUNS-1:0][RUN_W-1:0]      r_run;
  logic                                r_ovfPend;
  logic                                r_pubStage;

  logic [RUN_W-1:0] w_cnt;
  logic             w_acceptSop;
  logic             w_runPix;
  logic             w_sameSym;
  logic             w_cntLoad;
  logic             w_cntInc;

  // A sop is honoured in every state except the single PUBLISH cycle.
  assign w_acceptSop = pixel_valid && sop && (r_state != PUBLISH);
  assign w_runPix    = pixel_valid && !sop && (r_state == RUN);
  assign w_sameSym   = (pixel_bit == r_curSym);
  assign w_cntLoad   = w_acceptSop || (w_runPix && !w_sameSym && (r_idx != 2'd2));
  assign w_cntInc    = w_runPix && w_sameSym;

  rle_sat_counter u_cnt (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .load     (w_cntLoad),
    .load_val (RUN_W'(1)),
    .inc      (w_cntInc),
    .cnt      (w_cnt)
  );

  // Frame FSM plus the publish stage: PUBLISH folds the open run into its
  // slot, and the edge after it copies the slots onto the outputs.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_idx      <= 2'd0;
      r_curSym   <= 1'b0;
      r_run      <= {NUM_RUNS{EMPTY_CODE}};
      r_ovfPend  <= 1'b0;
      r_pubStage <= 1'b0;
      stream1    <= EMPTY_CODE;
      stream2    <= EMPTY_CODE;
      stream3    <= EMPTY_CODE;
      new_im     <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      new_im     <= 1'b0;
      r_pubStage <= 1'b0;

      if (r_pubStage) begin
        stream1  <= r_run[0];
        stream2  <= r_run[1];
        stream3  <= r_run[2];
        overflow <= r_ovfPend;
        new_im   <= 1'b1;
      end

      if (w_acceptSop) begin
        r_run     <= {NUM_RUNS{EMPTY_CODE}};
        r_ovfPend <= 1'b0;
        busy      <= 1'b1;
        if (pixel_bit) begin
          r_run[0] <= '0;
          r_idx    <= 2'd1;
          r_curSym <= 1'b1;
        end else begin
          r_idx    <= 2'd0;
          r_curSym <= 1'b0;
        end
        r_state <= eop ? PUBLISH : RUN;
      end else begin
        case (r_state)
          IDLE: begin
          end
          RUN: begin
            if (pixel_valid) begin
              if (!w_sameSym) begin
                r_run[r_idx] <= w_cnt;
                if (r_idx == 2'd2) begin
                  r_ovfPend <= 1'b1;
                  r_state   <= eop ? PUBLISH : DRAIN;
                end else begin
                  r_idx    <= r_idx + 2'd1;
                  r_curSym <= ~r_curSym;
                  if (eop) r_state <= PUBLISH;
                end
              end else if (eop) begin
                r_state <= PUBLISH;
              end
            end
          end
          DRAIN: begin
            if (pixel_valid && eop) r_state <= PUBLISH;
          end
          PUBLISH: begin
            if (!r_ovfPend) r_run[r_idx] <= w_cnt;
            r_pubStage <= 1'b1;
            r_state    <= IDLE;
            busy       <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rle_run_encoder.sv
// Self-checking bench for rle_run_encoder: table of frames, hand-written
// reset/restart sequences, and random frames against a run-list model.
module tb_rle_run_encoder;
  import rle_pkg::*;

  logic             CLK = 1'b0;
  logic             reset_n;
  logic             pixel_valid, pixel_bit, sop, eop;
  logic [RUN_W-1:0] stream1, stream2, stream3;
  logic             new_im, overflow, busy;

  int checkCount = 0;
  int passCount  = 0;
  int pulseCount = 0;
  bit frameBits[$];

  typedef struct {
    int               r0, r1, r2, r3, r4;
    logic [RUN_W-1:0] e1, e2, e3;
    logic             eo;
  } vec_t;
  vec_t vecs[8];

  rle_run_encoder dut (
    .CLK(CLK), .reset_n(reset_n), .pixel_valid(pixel_valid),
    .pixel_bit(pixel_bit), .sop(sop), .eop(eop),
    .stream1(stream1), .stream2(stream2), .stream3(stream3),
    .new_im(new_im), .overflow(overflow), .busy(busy)
  );

  // 10 ns clock
  always #5 CLK = ~CLK;

  // Count strobe cycles, sampled away from the active edge
  always @(negedge CLK) if (new_im === 1'b1) pulseCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drive one input cycle; returns 1 ns after the edge that sampled it
  task automatic applyStimulus(input logic v, input logic b, input logic s, input logic e);
    pixel_valid = v; pixel_bit = b; sop = s; eop = e;
    @(posedge CLK); #1;
    pixel_valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  task automatic sendFrame(input bit gaps);
    for (int i = 0; i < frameBits.size(); i++) begin
      if (gaps && $urandom_range(3) == 0)
        applyStimulus(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      applyStimulus(1'b1, frameBits[i], (i == 0), (i == frameBits.size() - 1));
    end
  endtask

  function automatic int runOf(input vec_t v, input int k);
    case (k)
      0: return v.r0;
      1: return v.r1;
      2: return v.r2;
      3: return v.r3;
      default: return v.r4;
    endcase
  endfunction

  function automatic void buildFrame(input vec_t v);
    frameBits.delete();
    for (int k = 0; k < 5; k++)
      for (int n = 0; n < runOf(v, k); n++) frameBits.push_back(bit'(k % 2));
  endfunction

  // Reference: split the frame into alternating runs starting with symbol 0
  task automatic modelExpect(output logic [RUN_W-1:0] e1, output logic [RUN_W-1:0] e2,
                             output logic [RUN_W-1:0] e3, output logic eo);
    int runs[$];
    int len = 0;
    bit sym = 1'b0;
    logic [RUN_W-1:0] slot[3];
    foreach (frameBits[i]) begin
      if (frameBits[i] == sym) len++;
      else begin
        runs.push_back(len);
        sym = ~sym;
        len = 1;
      end
    end
    runs.push_back(len);
    for (int k = 0; k < 3; k++)
      slot[k] = (k < runs.size()) ? RUN_W'((runs[k] > 1022) ? 1022 : runs[k]) : RUN_W'(1023);
    e1 = slot[0]; e2 = slot[1]; e3 = slot[2];
    eo = (runs.size() > 3);
  endtask

  // Called right after the eop pixel: strobe must appear two edges later
  task automatic waitPublish(input string tag, input logic [RUN_W-1:0] e1, input logic [RUN_W-1:0] e2,
                             input logic [RUN_W-1:0] e3, input logic eo);
    int seenAt = -1;
    bit holdOk = 1'b1;
    logic [RUN_W-1:0] h1 = stream1, h2 = stream2, h3 = stream3;
    for (int i = 1; i <= 8 && seenAt < 0; i++) begin
      @(negedge CLK);
      if (new_im === 1'b1) seenAt = i;
      else if (stream1 !== h1 || stream2 !== h2 || stream3 !== h3) holdOk = 1'b0;
    end
    checkOutput({tag, ".latency"}, seenAt, 3);
    checkOutput({tag, ".hold"}, 32'(holdOk), 1);
    checkOutput({tag, ".stream1"}, 32'(stream1), 32'(e1));
    checkOutput({tag, ".stream2"}, 32'(stream2), 32'(e2));
    checkOutput({tag, ".stream3"}, 32'(stream3), 32'(e3));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(eo));
    checkOutput({tag, ".busy"}, 32'(busy), 0);
    @(negedge CLK);
    checkOutput({tag, ".strobeLen"}, 32'(new_im), 0);
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [RUN_W-1:0] m1, m2, m3;
    logic             mo;
    int               p0;

    vecs[0] = '{5, 3, 2, 0, 0, 10'd5, 10'd3, 10'd2, 1'b0};
    vecs[1] = '{0, 4, 6, 0, 0, 10'd0, 10'd4, 10'd6, 1'b0};
    vecs[2] = '{1500, 0, 0, 0, 0, 10'd1022, 10'd1023, 10'd1023, 1'b0};
    vecs[3] = '{2, 2, 2, 3, 1, 10'd2, 10'd2, 10'd2, 1'b1};
    vecs[4] = '{1, 0, 0, 0, 0, 10'd1, 10'd1023, 10'd1023, 1'b0};
    vecs[5] = '{0, 1, 0, 0, 0, 10'd0, 10'd1, 10'd1023, 1'b0};
    vecs[6] = '{1, 1, 1, 1, 0, 10'd1, 10'd1, 10'd1, 1'b1};
    vecs[7] = '{2, 1025, 3, 0, 0, 10'd2, 10'd1022, 10'd3, 1'b0};

    reset_n = 1'b0; pixel_valid = 1'b0; pixel_bit = 1'b0; sop = 1'b0; eop = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset.stream1", 32'(stream1), 1023);
    checkOutput("reset.stream2", 32'(stream2), 1023);
    checkOutput("reset.stream3", 32'(stream3), 1023);
    checkOutput("reset.new_im", 32'(new_im), 0);
    checkOutput("reset.overflow", 32'(overflow), 0);
    checkOutput("reset.busy", 32'(busy), 0);
    #4 reset_n = 1'b1;
    @(posedge CLK); #1;

    // Table frames, odd entries with valid-low gaps sprinkled in
    for (int v = 0; v < 8; v++) begin
      buildFrame(vecs[v]);
      sendFrame(bit'(v % 2));
      waitPublish($sformatf("vec%0d", v), vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].eo);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Restart by a second sop in mid-frame: only the second frame publishes
    p0 = pulseCount;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'($urandom_range(1)), (i == 0), 1'b0);
    checkOutput("restart.busy", 32'(busy), 1);
    frameBits = '{0, 0, 0, 1, 1, 1};
    sendFrame(1'b0);
    waitPublish("restart", 10'd3, 10'd3, 10'd1023, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("restart.pulses", pulseCount - p0, 1);

    // Asynchronous reset in mid-frame, released between clock edges
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, (i == 0), 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midReset.stream1", 32'(stream1), 1023);
    checkOutput("midReset.stream2", 32'(stream2), 1023);
    checkOutput("midReset.busy", 32'(busy), 0);
    #5 reset_n = 1'b1;
    @(posedge CLK); #1;
    p0 = pulseCount;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, (i == 4));
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midReset.noPulse", pulseCount - p0, 0);
    checkOutput("midReset.stream3", 32'(stream3), 1023);
    frameBits = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    sendFrame(1'b1);
    waitPublish("afterReset", 10'd0, 10'd4, 10'd6, 1'b0);

    // Random frames against the run-list model
    for (int f = 0; f < 40; f++) begin
      int  len = 1 + $urandom_range(39);
      bit  b   = 1'($urandom_range(1));
      frameBits.delete();
      for (int i = 0; i < len; i++) begin
        frameBits.push_back(b);
        if ($urandom_range(3) == 0) b = ~b;
      end
      modelExpect(m1, m2, m3, mo);
      sendFrame(1'b1);
      waitPublish($sformatf("rand%0d", f), m1, m2, m3, mo);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
